heat_zone_ctrl: RTL and testbench
=================================

# heat_zone_ctrl

Parametrised multi-zone heating/cooling controller and successor to the single-zone `heating_dut`. Each of `NZONES` independent zones compares a signed fixed-point target temperature against the measured ambient temperature. Using hysteresis, each zone drives a heat or cool actuator request, subject to minimum-on and minimum-off (anti-short-cycle) timers. The block sits between the temperature sensor front-end, which supplies ambient readings and a sample strobe, and the actuator/LED drivers.

## Interface
- `NZONES`, 4: number of independent zones.
- `TW`, 12: temperature width, signed two's complement, `FRAC`=4 fractional bits (1 LSB = 1/16 °C).
- `HYST`, 32: hysteresis in temperature LSBs (2.0 °C).
- `MIN_ON`, 100: minimum clock cycles an actuator stays on once started.
- `MIN_OFF`, 50: clock cycles of lockout after any actuator stops.

Ports:
- `clock` in 1: single clock, all logic rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `sample` in 1: one-cycle strobe; a new ambient set is valid.
- `en` in NZONES: per-zone enable.
- `mode` in NZONES: per-zone mode, 0 = heat, 1 = cool.
- `target` in NZONES*TW: packed targets, zone i at `[i*TW +: TW]`.
- `ambient` in NZONES*TW: packed ambient readings, same packing.
- `heat_on` out NZONES: heat actuator request.
- `cool_on` out NZONES: cool actuator request.
- `LG` out NZONES: zone satisfied (IDLE and enabled).
- `LR` out NZONES: zone actuating (HEAT or COOL).
- `active_count` out $clog2(NZONES+1): number of zones with `LR`=1.

## Operation
Each zone runs its own FSM with four states: IDLE, HEAT, COOL, LOCKOUT. All comparisons are signed and performed in TW+1 bits so that `x + HYST` cannot overflow.

- **IDLE to HEAT:** `sample` & `en[i]` & `mode[i]`=0 & `target >= ambient + HYST`. The on-counter is cleared.
- **IDLE to COOL:** `sample` & `en[i]` & `mode[i]`=1 & `target + HYST <= ambient`. The on-counter is cleared.
- **HEAT to LOCKOUT:** `sample` & on-counter >= MIN_ON & `ambient >= target`.
- **COOL to LOCKOUT:** `sample` & on-counter >= MIN_ON & `ambient <= target`.
- **Forced exit:** HEAT/COOL go to LOCKOUT immediately on the next edge if `en[i]`=0 or `mode[i]` changes. This overrides MIN_ON.
- **LOCKOUT to IDLE:** when the off-counter reaches MIN_OFF. Re-entry to HEAT/COOL needs a later `sample`.
- **Counters:** the on-counter increments every cycle in HEAT/COOL and saturates at MIN_ON. The off-counter increments every cycle in LOCKOUT and is cleared on entry.
- **Strobe without enable:** `sample` with `en[i]`=0 is ignored in IDLE.
- **Mid-band readings:** readings inside the hysteresis band cause no transition.
- **Output decode:** `heat_on`=HEAT, `cool_on`=COOL, `LR`=HEAT|COOL, `LG`=IDLE & `en[i]`.
- **Active count:** `active_count` is the popcount of the registered `LR`.
- **Zone independence:** zones share no state. Simultaneous transitions in several zones are all taken on the same edge.

## Timing
- **Reset:** every zone is IDLE with counters 0. `heat_on`, `cool_on`, `LG`, `LR` and `active_count` are all 0. `LG` rises on the first edge after `rst` falls if `en[i]`=1.
- **Registered outputs:** all outputs are registered. A transition caused by `sample` in cycle N is visible in cycle N+1.
- **Exit timing:** the earliest exit is the first `sample` at least MIN_ON cycles after entry. A qualifying `sample` before that point is ignored and not remembered.
- **Lockout length:** LOCKOUT lasts exactly MIN_OFF cycles, then IDLE.
- **Reset mid-operation:** `rst` asserted in any state returns the zone to IDLE on that edge. Outputs drop without lockout.
- **Strobe precedence:** `sample` arriving in the same cycle as the end of LOCKOUT is not evaluated; the zone only becomes IDLE.

## Structure
- **Package `heat_pkg`:** `zone_state_t` enum (IDLE, HEAT, COOL, LOCKOUT), `FRAC` constant, and the mode encodings `MODE_HEAT`/`MODE_COOL`.
- **Sub-module `heat_zone_fsm`:** one zone's FSM, counters and output decode. Top generates `NZONES` instances plus the `active_count` popcount.
- **Counter width:** $clog2(max(MIN_ON,MIN_OFF)+1).

## Test plan
- **Heat engage:** zone 0, heat, `target`=288 (18.0), `ambient`=208 (13.0), pulse `sample` → `heat_on[0]`=1, `LR[0]`=1, `LG[0]`=0 next cycle, `active_count`=1.
- **Hysteresis hold:** heat, `target`=288, `ambient`=258 (16.125, inside band), repeated `sample` → no transition. With `ambient`=255, `sample` → HEAT.
- **Min-on/min-off:** in HEAT, `ambient`=300 sampled at cycle 10 → still on. At cycle ≥100 → off, `LR`=0, `LG`=0 for 50 cycles, then `LG`=1. A `sample` with `ambient`=200 during lockout → ignored.
- **Cool mode, negative temps:** zone 1, cool, `target`=-32 (-2.0), `ambient`=16 (1.0) → `cool_on[1]`=1. Then `target`=2047, `ambient`=2047 → no overflow, correct exit after MIN_ON.
- **Forced exit:** in HEAT, drop `en[0]` (or flip `mode[0]`) at cycle 5 → `heat_on[0]`=0 next cycle, LOCKOUT 50 cycles.
- **Multi-zone and reset:** all 4 zones engage on one `sample` → `active_count`=4. Assert `rst` → all outputs 0 next edge, no lockout.

Source files
------------

// File: rtl/heat_zone_ctrl_pkg.sv
// Purpose: shared types and constants for the multi-zone heat/cool controller.
// Latency: n/a (declarations only).
// Backpressure: n/a, no handshakes in this block.
package heat_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEAT    = 2'd1,
        COOL    = 2'd2,
        LOCKOUT = 2'd3
    } zone_state_t;

    // Fractional bits of the temperature format (1 LSB = 1/16 degC).
    localparam int FRAC = 4;

    localparam logic MODE_HEAT = 1'b0;
    localparam logic MODE_COOL = 1'b1;

    // One counter serves both the on-timer and the lockout timer, so it must
    // hold the larger of the two limits.
    function automatic int cnt_width(input int on_cyc, input int off_cyc);
        int m;
        m = (on_cyc > off_cyc) ? on_cyc : off_cyc;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/heat_zone_ctrl_fsm.sv
// Purpose: one zone's IDLE/HEAT/COOL/LOCKOUT controller with anti-short-cycle timers.
// Latency: decisions on a sample in cycle N appear on the registered outputs in cycle N+1.
// Backpressure: none; sample strobes not qualifying in the current state are dropped.
module heat_zone_fsm
    import heat_pkg::*;
#(
    parameter int TW      = 12,
    parameter int HYST    = 32,
    parameter int MIN_ON  = 100,
    parameter int MIN_OFF = 50
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_sample,
    input  logic          i_en,
    input  logic          i_mode,
    input  logic [TW-1:0] i_target,
    input  logic [TW-1:0] i_ambient,
    output logic          o_heat,
    output logic          o_cool,
    output logic          o_lg,
    output logic          o_lr
);

    localparam int CW = cnt_width(MIN_ON, MIN_OFF);
    localparam int XW = TW + 1;
    localparam logic [CW-1:0]        ON_LIM   = CW'(MIN_ON);
    localparam logic [CW-1:0]        OFF_LAST = CW'(MIN_OFF - 1);
    localparam logic signed [XW-1:0] HYST_X   = XW'(HYST);

    zone_state_t r_state;
    zone_state_t w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic r_heat;
    logic r_cool;
    logic r_lg;
    logic r_lr;

    // Temperatures are widened by one bit so adding the hysteresis cannot wrap.
    logic signed [XW-1:0] w_tgt;
    logic signed [XW-1:0] w_amb;
    logic w_heat_demand;
    logic w_cool_demand;
    logic w_heat_sat;
    logic w_cool_sat;
    logic w_on_done;

    assign w_tgt         = {i_target[TW-1], i_target};
    assign w_amb         = {i_ambient[TW-1], i_ambient};
    assign w_heat_demand = (w_tgt >= (w_amb + HYST_X));
    assign w_cool_demand = ((w_tgt + HYST_X) <= w_amb);
    assign w_heat_sat    = (w_amb >= w_tgt);
    assign w_cool_sat    = (w_amb <= w_tgt);
    assign w_on_done     = (r_cnt >= ON_LIM);

    // Next-state and shared timer: counts on-time in HEAT/COOL, off-time in LOCKOUT.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        case (r_state)
            IDLE: begin
                if (i_sample && i_en) begin
                    if ((i_mode == MODE_HEAT) && w_heat_demand) begin
                        w_state_nxt = HEAT;
                    end else if ((i_mode == MODE_COOL) && w_cool_demand) begin
                        w_state_nxt = COOL;
                    end
                end
            end
            HEAT: begin
                // Losing enable or changing mode aborts immediately, ignoring MIN_ON.
                if (!i_en || (i_mode != MODE_HEAT)) begin
                    w_state_nxt = LOCKOUT;
                end else if (i_sample && w_on_done && w_heat_sat) begin
                    w_state_nxt = LOCKOUT;
                end else begin
                    w_cnt_nxt = w_on_done ? r_cnt : r_cnt + CW'(1);
                end
            end
            COOL: begin
                if (!i_en || (i_mode != MODE_COOL)) begin
                    w_state_nxt = LOCKOUT;
                end else if (i_sample && w_on_done && w_cool_sat) begin
                    w_state_nxt = LOCKOUT;
                end else begin
                    w_cnt_nxt = w_on_done ? r_cnt : r_cnt + CW'(1);
                end
            end
            LOCKOUT: begin
                // Sample is deliberately not looked at here, even on the final cycle.
                if (r_cnt == OFF_LAST) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, timer and output registers; outputs decode the next state so they change with it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_heat  <= 1'b0;
            r_cool  <= 1'b0;
            r_lg    <= 1'b0;
            r_lr    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_heat  <= (w_state_nxt == HEAT);
            r_cool  <= (w_state_nxt == COOL);
            r_lr    <= (w_state_nxt == HEAT) || (w_state_nxt == COOL);
            r_lg    <= (w_state_nxt == IDLE) && i_en;
        end
    end

    assign o_heat = r_heat;
    assign o_cool = r_cool;
    assign o_lg   = r_lg;
    assign o_lr   = r_lr;

endmodule

// File: rtl/heat_zone_ctrl.sv
// Purpose: NZONES independent hysteresis heat/cool controllers plus an active-zone count.
// Latency: one cycle from sample/enable/mode to registered actuator and LED outputs.
// Backpressure: none; every zone evaluates each strobe on its own.
module heat_zone_ctrl
    import heat_pkg::*;
#(
    parameter int NZONES  = 4,
    parameter int TW      = 12,
    parameter int HYST    = 2 << heat_pkg::FRAC,
    parameter int MIN_ON  = 100,
    parameter int MIN_OFF = 50
) (
    input  logic                          clock,
    input  logic                          rst,
    input  logic                          sample,
    input  logic [NZONES-1:0]             en,
    input  logic [NZONES-1:0]             mode,
    input  logic [NZONES*TW-1:0]          target,
    input  logic [NZONES*TW-1:0]          ambient,
    output logic [NZONES-1:0]             heat_on,
    output logic [NZONES-1:0]             cool_on,
    output logic [NZONES-1:0]             LG,
    output logic [NZONES-1:0]             LR,
    output logic [$clog2(NZONES+1)-1:0]   active_count
);

    localparam int AW = $clog2(NZONES + 1);

    logic [AW-1:0] w_active;

    for (genvar gi = 0; gi < NZONES; gi++) begin : g_zone
        heat_zone_fsm #(
            .TW      (TW),
            .HYST    (HYST),
            .MIN_ON  (MIN_ON),
            .MIN_OFF (MIN_OFF)
        ) u_zone (
            .i_clk     (clock),
            .i_rst     (rst),
            .i_sample  (sample),
            .i_en      (en[gi]),
            .i_mode    (mode[gi]),
            .i_target  (target[gi*TW +: TW]),
            .i_ambient (ambient[gi*TW +: TW]),
            .o_heat    (heat_on[gi]),
            .o_cool    (cool_on[gi]),
            .o_lg      (LG[gi]),
            .o_lr      (LR[gi])
        );
    end

    // Popcount of the per-zone LR flops; depends only on registers, so no input path.
    always_comb begin
        w_active = '0;
        for (int i = 0; i < NZONES; i++) begin
            w_active = w_active + AW'(LR[i]);
        end
    end

    assign active_count = w_active;

endmodule

// File: tb/tb_heat_zone_ctrl.sv
// Purpose: scoreboard bench for heat_zone_ctrl against a behavioural zone model.
// Latency: expected outputs are queued per cycle and checked one cycle later.
// Backpressure: none; the monitor consumes one expectation per clock.
module tb_heat_zone_ctrl;

    localparam int NZ      = 4;
    localparam int TW      = 12;
    localparam int HYST    = 32;
    localparam int MIN_ON  = 100;
    localparam int MIN_OFF = 50;
    localparam int AW      = 3;

    localparam int P_IDLE = 0;
    localparam int P_HEAT = 1;
    localparam int P_COOL = 2;
    localparam int P_LOCK = 3;

    logic               clock;
    logic               rst;
    logic               sample;
    logic [NZ-1:0]      en;
    logic [NZ-1:0]      mode;
    logic [NZ*TW-1:0]   target;
    logic [NZ*TW-1:0]   ambient;
    logic [NZ-1:0]      heat_on;
    logic [NZ-1:0]      cool_on;
    logic [NZ-1:0]      LG;
    logic [NZ-1:0]      LR;
    logic [AW-1:0]      active_count;

    typedef struct packed {
        logic [NZ-1:0] heat;
        logic [NZ-1:0] cool;
        logic [NZ-1:0] lg;
        logic [NZ-1:0] lr;
        logic [AW-1:0] cnt;
    } obs_t;

    obs_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Stimulus temperatures (integers in degC/16) and model state per zone.
    int tg[NZ];
    int am[NZ];
    int m_ph[NZ];
    int m_age[NZ];
    int m_left[NZ];

    heat_zone_ctrl #(
        .NZONES  (NZ),
        .TW      (TW),
        .HYST    (HYST),
        .MIN_ON  (MIN_ON),
        .MIN_OFF (MIN_OFF)
    ) dut (
        .clock        (clock),
        .rst          (rst),
        .sample       (sample),
        .en           (en),
        .mode         (mode),
        .target       (target),
        .ambient      (ambient),
        .heat_on      (heat_on),
        .cool_on      (cool_on),
        .LG           (LG),
        .LR           (LR),
        .active_count (active_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Behavioural model: applies the zone rules to the inputs about to be
    // clocked and queues the outputs expected after that edge.
    task automatic model_step();
        obs_t e;
        int   t;
        int   a;
        bit   mz;
        bit   ez;
        bit   want_cool;
        e = '0;
        for (int z = 0; z < NZ; z++) begin
            t  = tg[z];
            a  = am[z];
            mz = mode[z];
            ez = en[z];
            if (rst) begin
                m_ph[z]   = P_IDLE;
                m_age[z]  = 0;
                m_left[z] = 0;
            end else begin
                case (m_ph[z])
                    P_IDLE: begin
                        if (sample && ez) begin
                            if (!mz && (t - a >= HYST)) begin
                                m_ph[z]  = P_HEAT;
                                m_age[z] = 0;
                            end else if (mz && (a - t >= HYST)) begin
                                m_ph[z]  = P_COOL;
                                m_age[z] = 0;
                            end
                        end
                    end
                    P_HEAT, P_COOL: begin
                        want_cool = (m_ph[z] == P_COOL);
                        if (!ez || (mz != want_cool)) begin
                            m_ph[z]   = P_LOCK;
                            m_left[z] = MIN_OFF;
                        end else if (sample && (m_age[z] >= MIN_ON) &&
                                     (want_cool ? (a <= t) : (a >= t))) begin
                            m_ph[z]   = P_LOCK;
                            m_left[z] = MIN_OFF;
                        end else begin
                            m_age[z] = m_age[z] + 1;
                        end
                    end
                    default: begin
                        m_left[z] = m_left[z] - 1;
                        if (m_left[z] == 0) m_ph[z] = P_IDLE;
                    end
                endcase
            end
            e.heat[z] = (m_ph[z] == P_HEAT);
            e.cool[z] = (m_ph[z] == P_COOL);
            e.lr[z]   = (m_ph[z] == P_HEAT) || (m_ph[z] == P_COOL);
            e.lg[z]   = !rst && (m_ph[z] == P_IDLE) && ez;
        end
        e.cnt = AW'($countones(e.lr));
        exp_q.push_back(e);
    endtask

    // Drive the current stimulus through one clock edge; returns at the next negedge.
    task automatic apply();
        for (int z = 0; z < NZ; z++) begin
            target[z*TW +: TW]  = TW'(tg[z]);
            ambient[z*TW +: TW] = TW'(am[z]);
        end
        model_step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic run(input int n);
        repeat (n) apply();
    endtask

    task automatic pulse();
        sample = 1'b1;
        apply();
        sample = 1'b0;
    endtask

    function automatic int clamp(input int v);
        if (v > 2047)  return 2047;
        if (v < -2048) return -2048;
        return v;
    endfunction

    // Monitor: compares every registered output against the queued expectation.
    initial begin
        obs_t e;
        obs_t got;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {heat_on, cool_on, LG, LR, active_count};
                n_tests++;
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL outputs t=%0t got heat=%b cool=%b lg=%b lr=%b cnt=%0d required heat=%b cool=%b lg=%b lr=%b cnt=%0d",
                             $time, got.heat, got.cool, got.lg, got.lr, got.cnt,
                             e.heat, e.cool, e.lg, e.lr, e.cnt);
                end
            end
        end
    end

    // Time limit so the run always ends.
    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        sample = 1'b0;
        en     = 4'b0001;
        mode   = 4'b0000;
        for (int z = 0; z < NZ; z++) begin
            tg[z] = 0; am[z] = 0; m_ph[z] = P_IDLE; m_age[z] = 0; m_left[z] = 0;
        end
        target  = '0;
        ambient = '0;

        // Reset, then LG follows enable one edge after release.
        run(3);
        rst = 1'b0;
        run(2);
        en = 4'b1111;
        run(1);

        // Zone 0 heat: in-band readings hold, exact band edge engages.
        tg[0] = 288;
        am[0] = 258;
        repeat (3) begin pulse(); run(2); end
        am[0] = 257;
        pulse(); run(2);
        am[0] = 256;
        pulse();
        run(9);
        // Satisfied reading too early is ignored, then sampled every cycle.
        am[0] = 300;
        pulse();
        run(5);
        repeat (100) pulse();
        // Lockout ignores strobes, including on its final cycle.
        am[0] = 200;
        repeat (55) pulse();
        // Forced exit by dropping enable, then by flipping mode.
        run(4);
        en[0] = 1'b0;
        run(3);
        en[0] = 1'b1;
        run(55);
        pulse();
        run(4);
        mode[0] = 1'b1;
        run(3);
        mode[0] = 1'b0;
        run(55);

        // Zone 1 cool with negative temperatures, then extreme equal readings.
        mode[1] = 1'b1;
        tg[1] = -32;
        am[1] = 16;
        pulse();
        run(5);
        tg[1] = 2047;
        am[1] = 2047;
        repeat (25) begin pulse(); run(4); end
        run(55);

        // All zones engage on one strobe, then reset drops them with no lockout.
        rst = 1'b1; run(1); rst = 1'b0; run(1);
        mode  = 4'b1010;
        tg[0] = 288;   am[0] = 208;
        tg[1] = -32;   am[1] = 16;
        tg[2] = 2047;  am[2] = 2015;
        tg[3] = -2048; am[3] = -2016;
        pulse();
        run(3);
        rst = 1'b1; run(1); rst = 1'b0;
        run(3);

        // Randomized traffic around each zone's target.
        for (int c = 0; c < 3000; c++) begin
            rst    = ($urandom_range(0, 399) == 0);
            sample = ($urandom_range(0, 3) == 0);
            for (int z = 0; z < NZ; z++) begin
                if ($urandom_range(0, 199) == 0) en[z] = ~en[z];
                if ($urandom_range(0, 299) == 0) mode[z] = ~mode[z];
                if ($urandom_range(0, 499) == 0) tg[z] = int'($urandom_range(0, 4095)) - 2048;
                if (sample) begin
                    if ($urandom_range(0, 49) == 0)
                        am[z] = ($urandom_range(0, 1) == 0) ? -2048 : 2047;
                    else
                        am[z] = clamp(tg[z] + int'($urandom_range(0, 160)) - 80);
                end
            end
            apply();
        end
        rst    = 1'b0;
        sample = 1'b0;
        run(2);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clock);
        end
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
